// File: rtl/cim_column_driver_if.sv
// Valid/ready bundle between tile controller and CIM column driver.
// Channels: weight stream (w_*), compute command (cmd_*), result (r_*).
interface cim_column_driver_if #(
    parameter int DATA_WIDTH  = 9,
    parameter int NUM_ROWS    = 32,
    parameter int ODATA_WIDTH = 21
);
    logic                             w_valid;
    logic                             w_ready;
    logic [DATA_WIDTH-1:0]            w_data;
    logic                             cmd_valid;
    logic                             cmd_ready;
    logic [NUM_ROWS*DATA_WIDTH-1:0]   cmd_act;
    logic                             r_valid;
    logic                             r_ready;
    logic [ODATA_WIDTH-1:0]           r_data;
    logic                             r_timeout;

    modport master (
        output w_valid, w_data, cmd_valid, cmd_act, r_ready,
        input  w_ready, cmd_ready, r_valid, r_data, r_timeout
    );

    modport slave (
        input  w_valid, w_data, cmd_valid, cmd_act, r_ready,
        output w_ready, cmd_ready, r_valid, r_data, r_timeout
    );
endinterface

// File: rtl/cim_column_driver.sv
// Host-side sequencer for one CIM column: loads NUM_ROWS weights, writes
// them in one column cycle, then runs compute commands and returns MAC sums.
// Ports: clk, rst (sync, active-high); bus (slave: w_*, cmd_*, r_*);
//   busy_o; col_en_o, col_sel_o, col_write_en_o, col_data_lines_o,
//   col_data_lines_n_o to the column; col_result_i, col_acc_ready_i from it.
// Option: define CIM_DRV_TIMEOUT_EN to abort COMPUTE after TIMEOUT_CYCLES.
module cim_column_driver #(
    parameter int DATA_WIDTH     = 9,
    parameter int NUM_ROWS       = 32,
    parameter int ODATA_WIDTH    = 21,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    cim_column_driver_if.slave             bus,
    output logic                           busy_o,
    output logic                           col_en_o,
    output logic                           col_sel_o,
    output logic                           col_write_en_o,
    output logic [NUM_ROWS*DATA_WIDTH-1:0] col_data_lines_o,
    output logic [NUM_ROWS*DATA_WIDTH-1:0] col_data_lines_n_o,
    input  logic [ODATA_WIDTH-1:0]         col_result_i,
    input  logic                           col_acc_ready_i
);
    localparam int VW    = NUM_ROWS * DATA_WIDTH;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_COMPUTE,
        S_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   loaded_q, loaded_d;
    logic [VW-1:0]          wsh_q, wsh_d;
    logic [VW-1:0]          act_q, act_d;
    logic [VW-1:0]          lines_q, lines_d;
    logic                   col_on_q, col_on_d;
    logic                   col_we_q, col_we_d;
    logic [ODATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic                   w_rdy, c_rdy, w_fire, c_fire;

`ifdef CIM_DRV_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          rto_q, rto_d;
`else
    logic          unused_to;
    assign unused_to = ^TIMEOUT_CYCLES;
`endif

    // A weight beat in IDLE takes priority over a waiting command.
    assign w_rdy  = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign c_rdy  = (state_q == S_IDLE) && loaded_q && !bus.w_valid;
    assign w_fire = bus.w_valid && w_rdy;
    assign c_fire = bus.cmd_valid && c_rdy;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        loaded_d = loaded_q;
        wsh_d    = wsh_q;
        act_d    = act_q;
        rdata_d  = rdata_q;
`ifdef CIM_DRV_TIMEOUT_EN
        tcnt_d   = tcnt_q;
        rto_d    = rto_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (w_fire) begin
                    wsh_d[0 +: DATA_WIDTH] = bus.w_data;
                    row_d    = ROW_W'(1);
                    loaded_d = 1'b0;
                    state_d  = S_LOAD;
                end else if (c_fire) begin
                    act_d   = bus.cmd_act;
                    state_d = S_COMPUTE;
`ifdef CIM_DRV_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            S_LOAD: begin
                if (w_fire) begin
                    wsh_d[row_q*DATA_WIDTH +: DATA_WIDTH] = bus.w_data;
                    if (row_q == ROW_W'(NUM_ROWS - 1)) begin
                        row_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            S_WRITE: begin
                loaded_d = 1'b1;
                state_d  = S_IDLE;
            end
            S_COMPUTE: begin
                if (col_acc_ready_i) begin
                    rdata_d = col_result_i;
`ifdef CIM_DRV_TIMEOUT_EN
                    rto_d   = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef CIM_DRV_TIMEOUT_EN
                // acc_ready on the last allowed cycle wins (checked first).
                else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    rto_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
`endif
            end
            S_RESP: begin
                if (bus.r_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Column outputs are registered from the next state so they line up
    // with the cycle the FSM spends in WRITE/COMPUTE.
    always_comb begin
        col_on_d = (state_d == S_WRITE) || (state_d == S_COMPUTE);
        col_we_d = (state_d == S_WRITE);
        rvalid_d = (state_d == S_RESP);
        lines_d  = lines_q;
        if (state_d == S_WRITE) begin
            lines_d = wsh_d;
        end else if (state_d == S_COMPUTE) begin
            lines_d = act_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            loaded_q <= 1'b0;
            wsh_q    <= '0;
            act_q    <= '0;
            lines_q  <= '0;
            col_on_q <= 1'b0;
            col_we_q <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            loaded_q <= loaded_d;
            wsh_q    <= wsh_d;
            act_q    <= act_d;
            lines_q  <= lines_d;
            col_on_q <= col_on_d;
            col_we_q <= col_we_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef CIM_DRV_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
            rto_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            rto_q  <= rto_d;
        end
    end
    assign bus.r_timeout = rto_q;
`else
    assign bus.r_timeout = 1'b0;
`endif

    assign bus.w_ready        = w_rdy;
    assign bus.cmd_ready      = c_rdy;
    assign bus.r_valid        = rvalid_q;
    assign bus.r_data         = rdata_q;
    assign busy_o             = (state_q != S_IDLE);
    assign col_en_o           = col_on_q;
    assign col_sel_o          = col_on_q;
    assign col_write_en_o     = col_we_q;
    assign col_data_lines_o   = lines_q;
    assign col_data_lines_n_o = ~lines_q;
endmodule

// File: tb/tb_cim_column_driver.sv
// Directed self-checking bench for cim_column_driver with a small
// column model that raises acc_ready a set number of cycles after col_en.
module tb_cim_column_driver;
    localparam int DW = 9;
    localparam int NR = 32;
    localparam int OW = 21;
    localparam int TO = 8;
    localparam int VW = NR * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy, col_en, col_sel, col_we, col_acc_ready;
    logic [VW-1:0] lines, lines_n;
    logic [OW-1:0] col_result;

    int            n_chk = 0;
    int            n_bad = 0;
    int            wr_cnt = 0;
    int            en_cnt = 0;
    int            acc_dly = 4;
    logic [OW-1:0] acc_val = '0;

    always #5 clk = ~clk;

    cim_column_driver_if #(
        .DATA_WIDTH (DW),
        .NUM_ROWS   (NR),
        .ODATA_WIDTH(OW)
    ) bus_if ();

    cim_column_driver #(
        .DATA_WIDTH    (DW),
        .NUM_ROWS      (NR),
        .ODATA_WIDTH   (OW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus_if),
        .busy_o            (busy),
        .col_en_o          (col_en),
        .col_sel_o         (col_sel),
        .col_write_en_o    (col_we),
        .col_data_lines_o  (lines),
        .col_data_lines_n_o(lines_n),
        .col_result_i      (col_result),
        .col_acc_ready_i   (col_acc_ready)
    );

    // Column model: count compute cycles since col_en rose.
    always @(posedge clk) begin
        en_cnt <= (col_en && !col_we) ? en_cnt + 1 : 0;
    end
    assign col_acc_ready = col_en && !col_we && (en_cnt == acc_dly);
    assign col_result    = acc_val;

    always @(negedge clk) begin
        if (col_we) wr_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lane_errs(input logic [VW-1:0] v, input int base,
                                     input int step);
        int e = 0;
        for (int k = 0; k < NR; k++) begin
            logic [DW-1:0] want;
            want = DW'(base + step * k);
            if (v[k*DW +: DW] !== want) e++;
        end
        return e;
    endfunction

    task automatic send_w(input logic [DW-1:0] d);
        int n = 0;
        bus_if.w_valid = 1'b1;
        bus_if.w_data  = d;
        #1;
        while (!bus_if.w_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("w_wait", 64'(n), 0);
        tick();
        bus_if.w_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [VW-1:0] act);
        int n = 0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_act   = act;
        #1;
        while (!bus_if.cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("cmd_wait", 64'(n), 0);
        tick();
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!bus_if.r_valid && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("resp_wait", 64'(n), 0);
    endtask

    task automatic take_resp();
        bus_if.r_ready = 1'b1;
        tick();
        bus_if.r_ready = 1'b0;
    endtask

    initial begin
        int            n;
        int            base;
        logic [VW-1:0] act;

        rst              = 1'b1;
        bus_if.w_valid   = 1'b0;
        bus_if.w_data    = '0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_act   = '0;
        bus_if.r_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_busy", 64'(busy), 0);
        check("rst_wrdy", 64'(bus_if.w_ready), 1);
        check("rst_crdy", 64'(bus_if.cmd_ready), 0);
        check("rst_col_en", 64'({col_en, col_sel, col_we}), 0);
        check("rst_rvalid", 64'(bus_if.r_valid), 0);
        check("rst_rdata", 64'(bus_if.r_data), 0);
        check("rst_rto", 64'(bus_if.r_timeout), 0);
        check("rst_lines0", 64'(lines == '0), 1);
        check("rst_lines_n1", 64'(&lines_n), 1);

        // 1: back-to-back load of k
        base = wr_cnt;
        for (int k = 0; k < NR; k++) send_w(DW'(k));
        check("t1_we", 64'(col_we), 1);
        check("t1_en_sel", 64'({col_en, col_sel}), 3);
        check("t1_wrdy_write", 64'(bus_if.w_ready), 0);
        tick();
        tick();
        check("t1_pulses", 64'(wr_cnt - base), 1);
        check("t1_lane0", 64'(lines[0 +: DW]), 0);
        check("t1_lane31", 64'(lines[31*DW +: DW]), 31);
        check("t1_lanes", 64'(lane_errs(lines, 0, 1)), 0);
        check("t1_lanes_n", 64'(lines_n == ~lines), 1);
        check("t1_crdy", 64'(bus_if.cmd_ready), 1);

        // 2: all-ones activations, result 496 after 4 cycles
        act = '0;
        for (int k = 0; k < NR; k++) act[k*DW +: DW] = DW'(1);
        acc_dly = 4;
        acc_val = OW'(496);
        send_cmd(act);
        check("t2_col_en", 64'(col_en), 1);
        check("t2_we", 64'(col_we), 0);
        check("t2_act", 64'(lane_errs(lines, 1, 0)), 0);
        wait_resp(n);
        check("t2_lat", 64'(n), 5);
        for (int i = 0; i < 3; i++) begin
            check("t2_rvalid_hold", 64'(bus_if.r_valid), 1);
            check("t2_rdata", 64'(bus_if.r_data), 496);
            check("t2_rto", 64'(bus_if.r_timeout), 0);
            tick();
        end
        take_resp();
        check("t2_rvalid_clr", 64'(bus_if.r_valid), 0);
        check("t2_busy", 64'(busy), 0);

        // 6: two back-to-back commands, no rewrite
        base = wr_cnt;
        acc_dly = 2;
        acc_val = OW'(7);
        send_cmd(act);
        wait_resp(n);
        check("t6_r0", 64'(bus_if.r_data), 7);
        take_resp();
        acc_val = OW'(9);
        send_cmd(act);
        wait_resp(n);
        check("t6_r1", 64'(bus_if.r_data), 9);
        take_resp();
        check("t6_no_write", 64'(wr_cnt - base), 0);

        // 4: beat and command together while loaded
        base = wr_cnt;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_act   = act;
        bus_if.w_valid   = 1'b1;
        bus_if.w_data    = DW'(100);
        #1;
        check("t4_crdy_tie", 64'(bus_if.cmd_ready), 0);
        check("t4_wrdy_tie", 64'(bus_if.w_ready), 1);
        send_w(DW'(100));
        check("t4_busy", 64'(busy), 1);
        check("t4_crdy_load", 64'(bus_if.cmd_ready), 0);
        for (int k = 1; k < NR; k++) send_w(DW'(100 + k));
        check("t4_crdy_write", 64'(bus_if.cmd_ready), 0);
        check("t4_lanes", 64'(lane_errs(lines, 100, 1)), 0);
        acc_dly = 3;
        acc_val = OW'(123);
        send_cmd(act);
        check("t4_after_write", 64'(wr_cnt - base), 1);
        wait_resp(n);
        check("t4_rdata", 64'(bus_if.r_data), 123);
        take_resp();

`ifdef CIM_DRV_TIMEOUT_EN
        // 5: timeout, then acc_ready on the final cycle
        acc_dly = 1000;
        acc_val = OW'(77);
        send_cmd(act);
        wait_resp(n);
        check("t5_to_lat", 64'(n), 8);
        check("t5_to_flag", 64'(bus_if.r_timeout), 1);
        check("t5_to_data", 64'(bus_if.r_data), 0);
        take_resp();
        acc_dly = 7;
        acc_val = OW'(55);
        send_cmd(act);
        wait_resp(n);
        check("t5_last_lat", 64'(n), 8);
        check("t5_last_flag", 64'(bus_if.r_timeout), 0);
        check("t5_last_data", 64'(bus_if.r_data), 55);
        take_resp();
`endif

        // 3: command before load, partial load, reset, full load
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_act   = act;
        #1;
        check("t3_crdy", 64'(bus_if.cmd_ready), 0);
        tick();
        tick();
        tick();
        check("t3_col_en", 64'(col_en), 0);
        check("t3_busy", 64'(busy), 0);
        bus_if.cmd_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_w(DW'(400 + k));
        end
        check("t3_busy_part", 64'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t3_rst_busy", 64'(busy), 0);
        check("t3_rst_lines", 64'(lines == '0), 1);
        for (int k = 0; k < NR; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_w(DW'(200 + k));
        end
        check("t3_we", 64'(col_we), 1);
        check("t3_lanes", 64'(lane_errs(lines, 200, 1)), 0);
        check("t3_lanes_n", 64'(lines_n == ~lines), 1);
        tick();
        check("t3_crdy_loaded", 64'(bus_if.cmd_ready), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
